// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: FSM encoding, default
// frame geometry and the RGB565 to RGB888 expansion.
package cam_pkg;

    localparam int FRAME_W_DEF = 640;
    localparam int FRAME_H_DEF = 480;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS_HI,
        ST_WAIT_VS_LO,
        ST_CAPTURE,
        ST_DONE
    } cam_state_t;

    // Low bits are refilled from the MSBs so full-scale 565 maps to 0xFF.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Two-flop synchronizer for one camera control line, with single-cycle
// rising and falling edge strobes derived from the synchronized level.
module cam_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/cam_capture.sv
// Parallel RGB565 camera capture: oversamples pclk/vsync/href on clk_sys and
// emits RGB888 pixels with x/y coordinates over a valid/ready handshake.
//
// state        | meaning
// ST_IDLE      | capture disabled, waiting for en
// ST_WAIT_VS_HI| waiting for vsync to go high (frame boundary)
// ST_WAIT_VS_LO| waiting for vsync to fall; start of active frame
// ST_CAPTURE   | assembling bytes into pixels, tracking x/y
// ST_DONE      | one-cycle frame wrap-up, frame_done pulse
module cam_capture
    import cam_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int X_BITS  = 12,
    parameter int Y_BITS  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              cam_pclk,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [23:0]       pix_data,
    output logic [X_BITS-1:0] pix_x,
    output logic [Y_BITS-1:0] pix_y,
    output logic              frame_start,
    output logic              frame_done,
    output logic [15:0]       frame_count,
    output logic              overflow,
    output logic              frame_err
);

    localparam logic [X_BITS-1:0] W_LIM = X_BITS'(FRAME_W);
    localparam logic [Y_BITS-1:0] H_LIM = Y_BITS'(FRAME_H);

    logic w_pclk_sync, w_pclk_rise, w_pclk_fall;
    logic w_vs, w_vs_rise, w_vs_fall;
    logic w_href, w_href_rise, w_href_fall;
    logic w_unused;

    cam_sync_edge u_sync_pclk (
        .clk    (clk),
        .reset  (reset),
        .i_async(cam_pclk),
        .o_sync (w_pclk_sync),
        .o_rise (w_pclk_rise),
        .o_fall (w_pclk_fall)
    );

    cam_sync_edge u_sync_vsync (
        .clk    (clk),
        .reset  (reset),
        .i_async(cam_vsync),
        .o_sync (w_vs),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    cam_sync_edge u_sync_href (
        .clk    (clk),
        .reset  (reset),
        .i_async(cam_href),
        .o_sync (w_href),
        .o_rise (w_href_rise),
        .o_fall (w_href_fall)
    );

    assign w_unused = &{w_pclk_sync, w_pclk_fall, w_vs_rise, w_vs_fall, w_href_rise};

    // Data takes the same two-flop path so it lines up with the pclk edge strobe.
    logic [7:0] r_d_meta;
    logic [7:0] r_d_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_meta <= 8'h00;
            r_d_sync <= 8'h00;
        end else begin
            r_d_meta <= cam_d;
            r_d_sync <= r_d_meta;
        end
    end

    cam_state_t        r_state;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [X_BITS-1:0] r_x;
    logic [Y_BITS-1:0] r_y;
    logic              r_pix_valid;
    logic [23:0]       r_pix_data;
    logic [X_BITS-1:0] r_pix_x;
    logic [Y_BITS-1:0] r_pix_y;
    logic              r_frame_start;
    logic              r_frame_done;
    logic [15:0]       r_frame_count;
    logic              r_overflow;
    logic              r_frame_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_phase       <= 1'b0;
            r_hi          <= 8'h00;
            r_x           <= '0;
            r_y           <= '0;
            r_pix_valid   <= 1'b0;
            r_pix_data    <= 24'h000000;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 16'h0000;
            r_overflow    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            if (r_pix_valid && pix_ready) begin
                r_pix_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (en) begin
                        r_state <= ST_WAIT_VS_HI;
                    end
                end
                ST_WAIT_VS_HI: begin
                    if (w_vs) begin
                        r_state <= ST_WAIT_VS_LO;
                    end
                end
                ST_WAIT_VS_LO: begin
                    if (!w_vs) begin
                        r_state <= ST_CAPTURE;
                        r_x     <= '0;
                        r_y     <= '0;
                        r_phase <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_vs) begin
                        r_state <= ST_DONE;
                        if (r_y != H_LIM) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_href_fall) begin
                        r_y     <= r_y + 1'b1;
                        r_x     <= '0;
                        r_phase <= 1'b0;
                        if (r_phase) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_pclk_rise && w_href) begin
                        if (!r_phase) begin
                            r_hi    <= r_d_sync;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            r_x     <= r_x + 1'b1;
                            if (r_x >= W_LIM) begin
                                r_frame_err <= 1'b1;
                            end else if (r_pix_valid && !pix_ready) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_pix_valid   <= 1'b1;
                                r_pix_data    <= rgb565_to_888({r_hi, r_d_sync});
                                r_pix_x       <= r_x;
                                r_pix_y       <= r_y;
                                r_frame_start <= (r_x == '0) && (r_y == '0);
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_frame_done  <= 1'b1;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_state       <= en ? ST_WAIT_VS_LO : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pix_valid   = r_pix_valid;
    assign pix_data    = r_pix_data;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign frame_err   = r_frame_err;

endmodule
